rgb2ycbcr_stream_ctrl: RTL and testbench

RGB2YCBCR_STREAM_CTRL -- requirements
Module: rgb2ycbcr_stream_ctrl

---
 rtl/rgb2ycbcr_stream_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rgb2ycbcr_stream_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_stream_ctrl.sv
// rgb2ycbcr_stream_ctrl
// Stream controller wrapped around an external fixed-latency RGB->YCbCr
// converter. Beats are issued to the converter, sideband tags ride a
// CVT_LAT-deep pipeline, and results land in a small output FIFO. Input
// backpressure reserves a FIFO slot for every beat still in the converter,
// so the FIFO cannot overflow.
// Optional build macro: YCC_LINE_CHECK_EN enables the sticky line-length error.
module rgb2ycbcr_stream_ctrl #(
  parameter int RGB_WIDTH   = 8,
  parameter int YCC_WIDTH   = 12,
  parameter int CVT_LAT     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int LINE_PIXELS = 3840
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RGB_WIDTH-1:0] in_r,
  input  logic [RGB_WIDTH-1:0] in_g,
  input  logic [RGB_WIDTH-1:0] in_b,
  input  logic                 in_sof,
  input  logic                 in_eol,
  output logic                 cvt_en,
  output logic [RGB_WIDTH-1:0] cvt_r,
  output logic [RGB_WIDTH-1:0] cvt_g,
  output logic [RGB_WIDTH-1:0] cvt_b,
  input  logic [YCC_WIDTH-1:0] cvt_y,
  input  logic [YCC_WIDTH-1:0] cvt_cb,
  input  logic [YCC_WIDTH-1:0] cvt_cr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [YCC_WIDTH-1:0] out_y,
  output logic [YCC_WIDTH-1:0] out_cb,
  output logic [YCC_WIDTH-1:0] out_cr,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 busy,
  output logic                 err_line_len
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 * YCC_WIDTH + 2;

  // Reject configurations the slot reservation scheme cannot support.
  if (CVT_LAT < 1 || FIFO_DEPTH < CVT_LAT + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    $error("rgb2ycbcr_stream_ctrl: bad CVT_LAT/FIFO_DEPTH");
  if (LINE_PIXELS < 1 || LINE_PIXELS > 65535)
    $error("rgb2ycbcr_stream_ctrl: LINE_PIXELS out of 16-bit range");

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   fifo_count_q, fifo_count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   head;
  logic [CVT_LAT:1] vld_pipe_q, sof_pipe_q, eol_pipe_q;
  logic [15:0]     pix_q, pix_d, pix_base, pix_inc;
  logic [CW:0]     occ;
  logic            space_ok, drop, accept, issue, capture, pop;

  // Occupancy counts both buffered entries and results still owed by the converter.
  assign occ      = {1'b0, fifo_count_q} + {1'b0, inflight_q};
  assign space_ok = (occ < (CW+1)'(FIFO_DEPTH));
  // In IDLE everything except an enabled start-of-frame is swallowed.
  assign drop     = (state_q == IDLE) && !(in_sof && cfg_enable);
  assign in_ready = !rst && (state_q != DRAIN) && (drop || space_ok);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && !drop;
  assign capture  = vld_pipe_q[CVT_LAT];
  assign pop      = out_valid && out_ready;

  assign cvt_en = issue;
  assign cvt_r  = in_r;
  assign cvt_g  = in_g;
  assign cvt_b  = in_b;

  // Next-state logic for the frame-level controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = RUN;
      RUN:     if (accept && in_eol && !cfg_enable) state_d = DRAIN;
      DRAIN:   if (fifo_count_q == '0 && inflight_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Valid/sof/eol tags shadow the converter so results are captured at exactly CVT_LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      sof_pipe_q <= '0;
      eol_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= issue;
      sof_pipe_q[1] <= in_sof;
      eol_pipe_q[1] <= in_eol;
      for (int k = 2; k <= CVT_LAT; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        sof_pipe_q[k] <= sof_pipe_q[k-1];
        eol_pipe_q[k] <= eol_pipe_q[k-1];
      end
    end
  end

  // In-flight and FIFO occupancy; simultaneous inc/dec cancel.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && !capture)      inflight_d = inflight_q + CW'(1);
    else if (!issue && capture) inflight_d = inflight_q - CW'(1);
    fifo_count_d = fifo_count_q;
    if (capture && !pop)        fifo_count_d = fifo_count_q + CW'(1);
    else if (!capture && pop)   fifo_count_d = fifo_count_q - CW'(1);
  end

  // Counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      if (capture) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= {cvt_y, cvt_cb, cvt_cr, sof_pipe_q[CVT_LAT], eol_pipe_q[CVT_LAT]};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (fifo_count_q != '0);
  assign out_y     = head[EW-1 -: YCC_WIDTH];
  assign out_cb    = head[2*YCC_WIDTH+1 -: YCC_WIDTH];
  assign out_cr    = head[YCC_WIDTH+1 -: YCC_WIDTH];
  assign out_sof   = head[1];
  assign out_eol   = head[0];
  assign busy      = (state_q != IDLE);

  // Pixel position within the line: sof restarts at 1, eol returns to 0, saturating.
  always_comb begin
    pix_base = in_sof ? 16'd0 : pix_q;
    pix_inc  = (pix_base == 16'hFFFF) ? pix_base : pix_base + 16'd1;
    pix_d    = pix_q;
    if (issue) pix_d = in_eol ? 16'd0 : pix_inc;
  end

  // Pixel counter register.
  always_ff @(posedge clk) begin
    if (rst) pix_q <= '0;
    else     pix_q <= pix_d;
  end

`ifdef YCC_LINE_CHECK_EN
  logic err_q;

  // Sticky flag: an issued eol whose line length differs from LINE_PIXELS.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (issue && in_eol && (pix_inc != 16'(LINE_PIXELS)))
      err_q <= 1'b1;
  end

  assign err_line_len = err_q;
`else
  assign err_line_len = 1'b0;
`endif

endmodule

// File: tb/tb_rgb2ycbcr_stream_ctrl.sv
// Scoreboard bench for rgb2ycbcr_stream_ctrl: the bench stands in for the
// converter, predicts issued pixels from the frame rules, and a separate
// monitor pops expectations as the DUT delivers output beats.
module tb_rgb2ycbcr_stream_ctrl;
  localparam int RW = 8, YW = 12, LAT = 2, FD = 4, LP = 3840;

  logic clk = 0, rst = 1, cfg_enable = 1;
  logic in_valid = 0, in_ready, in_sof = 0, in_eol = 0;
  logic [RW-1:0] in_r = 0, in_g = 0, in_b = 0;
  logic cvt_en;
  logic [RW-1:0] cvt_r, cvt_g, cvt_b;
  logic [YW-1:0] cvt_y, cvt_cb, cvt_cr;
  logic out_valid, out_ready = 1, out_sof, out_eol, busy, err_line_len;
  logic [YW-1:0] out_y, out_cb, out_cr;

  rgb2ycbcr_stream_ctrl #(.RGB_WIDTH(RW), .YCC_WIDTH(YW), .CVT_LAT(LAT),
                          .FIFO_DEPTH(FD), .LINE_PIXELS(LP)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_sof(in_sof), .in_eol(in_eol),
    .cvt_en(cvt_en), .cvt_r(cvt_r), .cvt_g(cvt_g), .cvt_b(cvt_b),
    .cvt_y(cvt_y), .cvt_cb(cvt_cb), .cvt_cr(cvt_cr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
    .out_sof(out_sof), .out_eol(out_eol),
    .busy(busy), .err_line_len(err_line_len));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [YW-1:0] y, cb, cr;
    logic sof, eol;
  } pix_t;

  pix_t sbq[$];
  int nvec = 0, nerr = 0, cyc = 0, n_out = 0;
  int rdy_mode = 0;
  bit in_frame = 0, exp_err = 0, arm_lat = 0, lat_pending = 0, iss, was;
  int mcnt = 0, lat_start = 0;

  // Reference transform of the stand-in converter.
  function automatic logic [YW-1:0] fy(input logic [RW-1:0] r, g, b);
    return YW'(r) + YW'({g, 1'b0}) + YW'(b);
  endfunction
  function automatic logic [YW-1:0] fcb(input logic [RW-1:0] g, b);
    return {b, g[3:0]};
  endfunction
  function automatic logic [YW-1:0] fcr(input logic [RW-1:0] r, g);
    return YW'(r * 13 + g);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in converter: operands issued LAT cycles ago come back transformed; junk otherwise.
  logic [3*RW:0] cpipe [LAT];
  logic [63:0] junk;
  always @(posedge clk) begin
    cpipe[0] <= {cvt_en, cvt_r, cvt_g, cvt_b};
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    junk <= {$urandom, $urandom};
  end
  always @* begin
    if (cpipe[LAT-1][3*RW] === 1'b1) begin
      cvt_y  = fy(cpipe[LAT-1][3*RW-1 -: RW], cpipe[LAT-1][2*RW-1 -: RW], cpipe[LAT-1][RW-1:0]);
      cvt_cb = fcb(cpipe[LAT-1][2*RW-1 -: RW], cpipe[LAT-1][RW-1:0]);
      cvt_cr = fcr(cpipe[LAT-1][3*RW-1 -: RW], cpipe[LAT-1][2*RW-1 -: RW]);
    end else begin
      cvt_y  = junk[YW-1:0];
      cvt_cb = junk[2*YW-1 -: YW];
      cvt_cr = junk[3*YW-1 -: YW];
    end
  end

  // out_ready pattern: 0 = always ready, 1 = random, 2 = stalled.
  initial forever begin
    @(posedge clk); #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Stimulus side: predict which accepted beats are issued and push their results.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      in_frame = 0; mcnt = 0; exp_err = 0; lat_pending = 0;
    end else if (in_valid) begin
      iss = in_valid && in_ready && (in_frame || (in_sof && cfg_enable));
      chk("cvt_en", cvt_en, iss);
      if (iss) begin
        chk("cvt_operands", {cvt_r, cvt_g, cvt_b}, {in_r, in_g, in_b});
        sbq.push_back(pix_t'{fy(in_r, in_g, in_b), fcb(in_g, in_b), fcr(in_r, in_g), in_sof, in_eol});
        if (arm_lat) begin lat_start = cyc; lat_pending = 1; arm_lat = 0; end
        mcnt = in_sof ? 1 : (mcnt < 65535 ? mcnt + 1 : mcnt);
        if (in_eol) begin
`ifdef YCC_LINE_CHECK_EN
          if (mcnt != LP) exp_err = 1;
`endif
          mcnt = 0;
        end
        was = in_frame;
        in_frame = 1;
        if (was && in_eol && !cfg_enable) in_frame = 0;
      end
    end
  end

  // Monitor: every output handshake must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (lat_pending && out_valid) begin
        chk("first_latency", 64'(cyc - lat_start), LAT + 1);
        lat_pending = 0;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_output: got y=%0h sof=%0b eol=%0b, expected none", out_y, out_sof, out_eol);
        end else begin
          chk("out_pixel", {out_y, out_cb, out_cr, out_sof, out_eol}, sbq.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit sof, input bit eol);
    in_valid = 1; in_sof = sof; in_eol = eol;
    in_r = RW'($urandom); in_g = RW'($urandom); in_b = RW'($urandom);
  endtask

  task automatic wait_acc();
    bit got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin nvec++; nerr++; $display("FAIL accept_timeout: in_ready stayed 0, expected 1"); end
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0; in_eol = 0;
  endtask

  task automatic send(input bit sof, input bit eol);
    drive(sof, eol);
    wait_acc();
  endtask

  task automatic wait_empty();
    int quiet = 0;
    bit got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      quiet = out_valid ? 0 : quiet + 1;
      if (quiet > LAT + 2) begin got = 1; break; end
    end
    if (!got) begin nvec++; nerr++; $display("FAIL drain_timeout: out_valid stuck 1, expected 0"); end
    chk("scoreboard_empty", 64'(sbq.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1; in_valid = 1; in_sof = 0; in_eol = 0;
    @(negedge clk);
    chk("in_ready_in_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_line_len, 0);
    chk("rst_cvt_en", cvt_en, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, n0, len;
    bit got;

    // Full 3840-pixel line at full rate.
    do_rst();
    arm_lat = 1;
    n0 = n_out; t0 = cyc;
    for (int i = 0; i < LP; i++) send(i == 0, i == LP - 1);
    chk("throughput_cycles", 64'(cyc - t0), LP);
    wait_empty();
    chk("line_outputs", 64'(n_out - n0), LP);
    chk("err_full_line", err_line_len, exp_err);

    // IDLE drops beats without sof (and sof while disabled).
    do_rst();
    for (int i = 0; i < 8; i++) begin
      cfg_enable = (i != 5);
      drive(i == 5, 0);
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      @(posedge clk); #1;
    end
    in_valid = 0; in_sof = 0; cfg_enable = 1;
    wait_empty();

    // Output stall: only FD beats fit, then backpressure until resumed.
    rdy_mode = 2;
    for (int i = 0; i < FD; i++) send(i == 0, 0);
    drive(0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
    end
    rdy_mode = 0;
    wait_acc();
    for (int i = 0; i < 20; i++) send(0, i == 19);
    wait_empty();

    // Disable mid-line: eol moves to DRAIN, input held off until empty.
    for (int i = 0; i < LP; i++) begin
      if (i == 2000) cfg_enable = 0;
      send(i == 0, i == LP - 1);
    end
    rdy_mode = 1;
    drive(0, 0);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) chk("drain_busy", busy, 1);
      if (busy) chk("drain_in_ready", in_ready, 0);
      else begin chk("drain_done_empty", out_valid, 0); got = 1; break; end
    end
    if (!got) begin nvec++; nerr++; $display("FAIL drain_exit: busy stuck 1, expected 0"); end
    @(posedge clk); #1;
    in_valid = 0; rdy_mode = 0; cfg_enable = 1;
    wait_empty();

    // Short line: eol at pixel 100.
    do_rst();
    for (int i = 0; i < 100; i++) send(i == 0, i == 99);
    @(negedge clk);
    chk("err_after_short_eol", err_line_len, exp_err);
    repeat (20) @(negedge clk);
    chk("err_held", err_line_len, exp_err);
    wait_empty();

    // Reset with pixels both buffered and inside the converter.
    rdy_mode = 2;
    for (int i = 0; i < FD; i++) send(i == 0, 0);
    do_rst();
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_stale_output", out_valid, 0);
    end
    @(posedge clk); #1;

    // Random lines with gaps and random backpressure; last line drains.
    rdy_mode = 1;
    for (int l = 0; l < 6; l++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (l == 5 && i == len - 1) cfg_enable = 0;
        send(i == 0, i == len - 1);
      end
    end
    rdy_mode = 0;
    wait_empty();
    chk("final_busy", busy, 0);
    chk("final_err", err_line_len, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
